// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit processor front end and control unit.
//   - Default address/instruction widths
//   - Opcode field position and the HALT opcode
//   - Fetch FSM state encoding
package cpu_pkg;

  localparam int unsigned DEF_ADDR_W  = 8;
  localparam int unsigned DEF_INSTR_W = 16;

  // Opcode is the top OPC_W bits of the instruction word.
  localparam int unsigned OPC_W = 5;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b11111;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFetch  = 2'd1,
    StHalted = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register for the fetch stage.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : pc <- 0 (highest priority)
//   load_i        : pc <- target_i
//   incr_i        : pc <- pc + 1, wrapping modulo 2^ADDR_W
//   pc_o          : current PC (held when no control is asserted)
module fetch_pc #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic              incr_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (clear_i) begin
      pc_d = '0;
    end else if (load_i) begin
      pc_d = target_i;
    end else if (incr_i) begin
      pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory and hands
// registered instructions downstream over a valid/ready handshake.
//   start_i / finish_i           : begin fetching at 0 / abort to idle
//   imem_addr_o / imem_data_i    : instruction memory read port (comb. data)
//   jump_taken_i / jump_target_i : redirect from the jump unit
//   instr_valid_o / instr_ready_i: downstream handshake
//   instr_o / instr_pc_o         : registered instruction and its address
//   halted_o                     : high while stopped on a HALT opcode
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned INSTR_W = DEF_INSTR_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               finish_i,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_data_i,
  input  logic               jump_taken_i,
  input  logic [ADDR_W-1:0]  jump_target_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o,
  output logic               halted_o
);

  fetch_state_e state_d, state_q;
  logic               valid_d, valid_q;
  logic [INSTR_W-1:0] instr_d, instr_q;
  logic [ADDR_W-1:0]  instr_pc_d, instr_pc_q;

  logic              pc_clear, pc_load, pc_incr;
  logic [ADDR_W-1:0] pc;
  logic [OPC_W-1:0]  opcode;

  assign opcode = imem_data_i[INSTR_W-1 -: OPC_W];

  fetch_pc #(
    .ADDR_W (ADDR_W)
  ) u_fetch_pc (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (pc_clear),
    .load_i   (pc_load),
    .target_i (jump_target_i),
    .incr_i   (pc_incr),
    .pc_o     (pc)
  );

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    pc_clear   = 1'b0;
    pc_load    = 1'b0;
    pc_incr    = 1'b0;

    if (finish_i) begin
      state_d = StIdle;
      valid_d = 1'b0;
    end else if (start_i && (state_q != StFetch)) begin
      state_d  = StFetch;
      pc_clear = 1'b1;
      valid_d  = 1'b0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (jump_taken_i) begin
            // Redirect drops the wrong-path word even if it is being accepted.
            pc_load = 1'b1;
            valid_d = 1'b0;
          end else if (!valid_q || instr_ready_i) begin
            instr_d    = imem_data_i;
            instr_pc_d = pc;
            valid_d    = 1'b1;
            if (opcode == OPC_HALT) begin
              // HALT is still delivered; PC parks on it.
              state_d = StHalted;
            end else begin
              pc_incr = 1'b1;
            end
          end
        end
        StIdle, StHalted: begin
          if (instr_ready_i) begin
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign imem_addr_o   = pc;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign halted_o      = (state_q == StHalted);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a cycle-level reference model
// checked every cycle, plus literal expectations along the scenario.
module tb_instruction_fetch;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        finish_i = 1'b0;
  logic [7:0]  imem_addr_o;
  logic [15:0] imem_data_i;
  logic        jump_taken_i = 1'b0;
  logic [7:0]  jump_target_i = 8'h00;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b1;
  logic [15:0] instr_o;
  logic [7:0]  instr_pc_o;
  logic        halted_o;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [256];
  assign imem_data_i = mem[imem_addr_o];

  instruction_fetch dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .finish_i      (finish_i),
    .imem_addr_o   (imem_addr_o),
    .imem_data_i   (imem_data_i),
    .jump_taken_i  (jump_taken_i),
    .jump_target_i (jump_target_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .halted_o      (halted_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 fetching, 2 halted.
  int         m_mode;
  logic [7:0] m_pc;
  logic       m_valid;
  logic [15:0] m_instr;
  logic [7:0] m_ipc;

  function automatic bit is_halt(input logic [15:0] w);
    return w[15:11] == 5'b11111;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_mode <= 0; m_pc <= 8'h00; m_valid <= 1'b0; m_instr <= 16'h0; m_ipc <= 8'h00;
    end else if (finish_i) begin
      m_mode <= 0; m_valid <= 1'b0;
    end else if (start_i && m_mode != 1) begin
      m_mode <= 1; m_pc <= 8'h00; m_valid <= 1'b0;
    end else if (m_mode == 1) begin
      if (jump_taken_i) begin
        m_pc <= jump_target_i; m_valid <= 1'b0;
      end else if (!m_valid || instr_ready_i) begin
        m_instr <= mem[m_pc]; m_ipc <= m_pc; m_valid <= 1'b1;
        if (is_halt(mem[m_pc])) m_mode <= 2;
        else m_pc <= m_pc + 8'd1;
      end
    end else if (instr_ready_i) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk_i) begin
    if (rst_ni) begin
      check("model_addr", imem_addr_o, m_pc);
      check("model_valid", instr_valid_o, m_valid);
      check("model_halted", halted_o, m_mode == 2);
      if (m_valid) begin
        check("model_instr", instr_o, m_instr);
        check("model_ipc", instr_pc_o, m_ipc);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic expect_out(input string name, input logic v, input logic [15:0] ins,
                            input logic [7:0] ipc, input logic [7:0] addr, input logic h);
    check({name, "_valid"}, instr_valid_o, v);
    if (v) begin
      check({name, "_instr"}, instr_o, ins);
      check({name, "_ipc"}, instr_pc_o, ipc);
    end
    check({name, "_addr"}, imem_addr_o, addr);
    check({name, "_halted"}, halted_o, h);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'(i);
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    mem[4] = 16'h5555; mem[5] = 16'hF800;
    mem[8'h40] = 16'hA040; mem[8'h41] = 16'hA041; mem[8'hFF] = 16'h0BFF;

    // Reset state
    #12;
    expect_out("reset", 1'b0, 16'h0, 8'h0, 8'h00, 1'b0);
    check("reset_instr", instr_o, 16'h0000);
    check("reset_ipc", instr_pc_o, 8'h00);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();

    // Straight line
    start_i = 1'b1; step(); start_i = 1'b0;
    expect_out("start", 1'b0, 16'h0, 8'h0, 8'h00, 1'b0);
    step(); expect_out("line0", 1'b1, 16'h1111, 8'h00, 8'h01, 1'b0);
    step(); expect_out("line1", 1'b1, 16'h2222, 8'h01, 8'h02, 1'b0);

    // Backpressure
    instr_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); expect_out("stall", 1'b1, 16'h2222, 8'h01, 8'h02, 1'b0);
    end
    instr_ready_i = 1'b1;
    step(); expect_out("release", 1'b1, 16'h3333, 8'h02, 8'h03, 1'b0);

    // Redirect
    jump_taken_i = 1'b1; jump_target_i = 8'h40;
    step(); jump_taken_i = 1'b0;
    expect_out("jmp_bubble", 1'b0, 16'h0, 8'h0, 8'h40, 1'b0);
    step(); expect_out("jmp_tgt", 1'b1, 16'hA040, 8'h40, 8'h41, 1'b0);

    // HALT
    jump_taken_i = 1'b1; jump_target_i = 8'h04;
    step(); jump_taken_i = 1'b0;
    step(); expect_out("pre_halt", 1'b1, 16'h5555, 8'h04, 8'h05, 1'b0);
    step(); expect_out("halt", 1'b1, 16'hF800, 8'h05, 8'h05, 1'b1);
    instr_ready_i = 1'b0;
    jump_taken_i = 1'b1; jump_target_i = 8'h40;
    step(); expect_out("halt_hold", 1'b1, 16'hF800, 8'h05, 8'h05, 1'b1);
    jump_taken_i = 1'b0;
    instr_ready_i = 1'b1;
    step(); expect_out("halt_drain", 1'b0, 16'h0, 8'h0, 8'h05, 1'b1);
    step(); expect_out("halt_idle", 1'b0, 16'h0, 8'h0, 8'h05, 1'b1);
    start_i = 1'b1; step(); start_i = 1'b0;
    expect_out("restart", 1'b0, 16'h0, 8'h0, 8'h00, 1'b0);
    step(); expect_out("restart0", 1'b1, 16'h1111, 8'h00, 8'h01, 1'b0);

    // Wrap
    jump_taken_i = 1'b1; jump_target_i = 8'hFF;
    step(); jump_taken_i = 1'b0;
    expect_out("wrap_bubble", 1'b0, 16'h0, 8'h0, 8'hFF, 1'b0);
    step(); expect_out("wrap_ff", 1'b1, 16'h0BFF, 8'hFF, 8'h00, 1'b0);
    step(); expect_out("wrap_00", 1'b1, 16'h1111, 8'h00, 8'h01, 1'b0);

    // Finish abort: pc held
    finish_i = 1'b1; step(); finish_i = 1'b0;
    expect_out("finish", 1'b0, 16'h0, 8'h0, 8'h01, 1'b0);
    step(); expect_out("idle", 1'b0, 16'h0, 8'h0, 8'h01, 1'b0);

    // Redirect while stalled
    start_i = 1'b1; step(); start_i = 1'b0;
    step(); expect_out("s2_line0", 1'b1, 16'h1111, 8'h00, 8'h01, 1'b0);
    instr_ready_i = 1'b0; jump_taken_i = 1'b1; jump_target_i = 8'h41;
    step(); expect_out("stall_jmp", 1'b0, 16'h0, 8'h0, 8'h41, 1'b0);
    instr_ready_i = 1'b1; jump_taken_i = 1'b0;
    step(); expect_out("stall_jmp_tgt", 1'b1, 16'hA041, 8'h41, 8'h42, 1'b0);
    step(); expect_out("after_tgt", 1'b1, 16'h0142, 8'h42, 8'h43, 1'b0);

    // Asynchronous reset between edges
    #2 rst_ni = 1'b0;
    #1;
    expect_out("async_rst", 1'b0, 16'h0, 8'h0, 8'h00, 1'b0);
    check("async_rst_instr", instr_o, 16'h0000);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(); expect_out("post_rst", 1'b0, 16'h0, 8'h0, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
